// File: rtl/avr_data_mem.sv
// AVR data-space slave: SRAM, GPIO port, UART transmitter and optional 16-bit timer.
// Define AVR_DATA_MEM_TIMER_EN to build the timer and its 0x44/0x45 registers.
module avr_data_mem #(
   parameter int unsigned RAM_BITS = 10,
   parameter int unsigned CLK_DIV  = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic        wen,
   input  logic        ren,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   input  logic [7:0]  gpio_in,
   output logic [7:0]  gpio_out,
   output logic        uart_tx
);

   localparam int unsigned RAM_SIZE = 1 << RAM_BITS;
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } tx_state_e;

   logic [7:0]          mem [0:RAM_SIZE-1];
   logic [RAM_BITS-1:0] ram_idx;
   logic                is_io;
   logic                is_ram;

   logic [7:0]  rdata_q, rdata_d;
   logic [7:0]  rd_val;
   logic [7:0]  portb_q, portb_d;
   logic [7:0]  sync1_q, sync2_q;
   logic        ovr_q, ovr_d;
   tx_state_e   st_q, st_d;
   logic [15:0] div_q, div_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shreg_q, shreg_d;
   logic        tx_q, tx_d;
   logic        tx_busy;
   logic        udr_wr;
   logic        ustat_wr;

   assign ram_idx  = addr[RAM_BITS-1:0];
   assign is_io    = (addr >= 16'h0020) && (addr <= 16'h005F);
   assign is_ram   = (addr >= 16'h0060);
   assign udr_wr   = wen && (addr == 16'h0046);
   assign ustat_wr = wen && (addr == 16'h0047);
   assign tx_busy  = (st_q != S_IDLE);

   assign rdata    = rdata_q;
   assign gpio_out = portb_q;
   assign uart_tx  = tx_q;

`ifdef AVR_DATA_MEM_TIMER_EN
   logic [15:0] tcnt_q;
   logic [7:0]  ttmp_q, ttmp_d;

   // High byte is captured on the low-byte read so a low-then-high pair is atomic.
   always_comb begin
      ttmp_d = ttmp_q;
      if (ren && (addr == 16'h0044)) ttmp_d = tcnt_q[15:8];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt_q <= '0;
         ttmp_q <= '0;
      end else begin
         tcnt_q <= tcnt_q + 16'd1;
         ttmp_q <= ttmp_d;
      end
   end
`endif

   // SRAM has no reset; the read below sees pre-write contents on a same-cycle access.
   always_ff @(posedge clk) begin
      if (wen && is_ram) mem[ram_idx] <= wdata;
   end

   always_comb begin
      rd_val = '0;
      if (is_ram) begin
         rd_val = mem[ram_idx];
      end else if (is_io) begin
         case (addr[7:0])
            8'h23:   rd_val = sync2_q;
            8'h25:   rd_val = portb_q;
`ifdef AVR_DATA_MEM_TIMER_EN
            8'h44:   rd_val = tcnt_q[7:0];
            8'h45:   rd_val = ttmp_q;
`endif
            8'h47:   rd_val = {6'b000000, ovr_q, tx_busy};
            default: rd_val = '0;
         endcase
      end
      rdata_d = ren ? rd_val : rdata_q;
      portb_d = (wen && (addr == 16'h0025)) ? wdata : portb_q;
   end

   always_comb begin
      st_d    = st_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      ovr_d   = ovr_q;
      tx_d    = 1'b1;

      if (ustat_wr && wdata[1]) ovr_d = 1'b0;

      case (st_q)
         S_IDLE: begin
            if (udr_wr) begin
               shreg_d = wdata;
               div_d   = '0;
               st_d    = S_START;
            end
         end
         S_START: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               bit_d = '0;
               st_d  = S_DATA;
            end else begin
               div_d = div_q + 16'd1;
            end
         end
         S_DATA: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               if (bit_q == 3'd7) st_d = S_STOP;
               else               bit_d = bit_q + 3'd1;
            end else begin
               div_d = div_q + 16'd1;
            end
         end
         S_STOP: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               st_d  = S_IDLE;
            end else begin
               div_d = div_q + 16'd1;
            end
         end
         default: st_d = S_IDLE;
      endcase

      // Evaluated after the clear so a dropped write in the same cycle keeps the flag set.
      if (udr_wr && tx_busy) ovr_d = 1'b1;

      // Line is registered from the next state so it changes on the same edge as the FSM.
      case (st_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shreg_d[bit_d];
         default: tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         portb_q <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         ovr_q   <= 1'b0;
         st_q    <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         rdata_q <= rdata_d;
         portb_q <= portb_d;
         sync1_q <= gpio_in;
         sync2_q <= sync1_q;
         ovr_q   <= ovr_d;
         st_q    <= st_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: tb/tb_avr_data_mem.sv
// Scoreboard bench for avr_data_mem: directed scenarios plus random traffic against a cycle-indexed model.
module tb_avr_data_mem;

   localparam int unsigned RB     = 10;
   localparam int unsigned CD     = 4;
   localparam int unsigned RAM_SZ = 1 << RB;
   localparam int          FRAME  = 10 * CD;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] addr = '0;
   logic        wen = 1'b0;
   logic        ren = 1'b0;
   logic [7:0]  wdata = '0;
   logic [7:0]  rdata;
   logic [7:0]  gpio_in = '0;
   logic [7:0]  gpio_out;
   logic        uart_tx;

   avr_data_mem #(.RAM_BITS(RB), .CLK_DIV(CD)) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .wen      (wen),
      .ren      (ren),
      .wdata    (wdata),
      .rdata    (rdata),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .uart_tx  (uart_tx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Clock edges seen since reset release; equals the timer value in that cycle.
   int cyc = 0;
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Reference model state
   logic [7:0] ram_m  [RAM_SZ];
   bit         ram_ok [RAM_SZ];
   logic [7:0] portb_m  = '0;
   bit         ovr_m    = 1'b0;
   int         tx_start = -100000;
   logic [7:0] tx_byte  = '0;
   logic [7:0] ttmp_m   = '0;
   logic [7:0] gpio_at [int];

   typedef struct {
      logic [7:0] v;
      bit         chk;
      string      nm;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic bit busy_at(int c);
      return (c >= tx_start) && (c < tx_start + FRAME);
   endfunction

   // Frame = start bit, 8 data bits LSB first, stop bit; each CD cycles.
   function automatic logic tx_model(int c);
      int k;
      if (!busy_at(c)) return 1'b1;
      k = (c - tx_start) / CD;
      if (k == 0) return 1'b0;
      if (k <= 8) return tx_byte[k-1];
      return 1'b1;
   endfunction

   function automatic logic [7:0] model_read(logic [15:0] a, output bit known);
      int idx;
      known = 1'b1;
      if (a < 16'h0020) return 8'h00;
      if (a < 16'h0060) begin
         case (a)
            16'h0023: return gpio_at.exists(cyc - 2) ? gpio_at[cyc - 2] : 8'h00;
            16'h0025: return portb_m;
`ifdef AVR_DATA_MEM_TIMER_EN
            16'h0044: return cyc[7:0];
            16'h0045: return ttmp_m;
`endif
            16'h0047: return {6'b000000, ovr_m, busy_at(cyc)};
            default:  return 8'h00;
         endcase
      end
      idx   = int'(a) % RAM_SZ;
      known = ram_ok[idx];
      return ram_m[idx];
   endfunction

   task automatic model_write(logic [15:0] a, logic [7:0] d);
      int idx;
      if (a >= 16'h0060) begin
         idx = int'(a) % RAM_SZ;
         ram_m[idx]  = d;
         ram_ok[idx] = 1'b1;
      end else if (a == 16'h0025) begin
         portb_m = d;
      end else if (a == 16'h0046) begin
         if (busy_at(cyc)) ovr_m = 1'b1;
         else begin
            tx_start = cyc + 1;
            tx_byte  = d;
         end
      end else if (a == 16'h0047) begin
         if (d[1]) ovr_m = 1'b0;
      end
   endtask

   // One bus cycle; called at a falling edge, returns at the next falling edge.
   task automatic op(bit w, bit r, logic [15:0] a, logic [7:0] d, int force_exp, string nm);
      exp_t       e;
      bit         known;
      logic [7:0] mv;
      #1;
      wen = w; ren = r; addr = a; wdata = d;
      if (r) begin
         mv    = model_read(a, known);
         e.v   = (force_exp >= 0) ? force_exp[7:0] : mv;
         e.chk = (force_exp >= 0) || known;
         e.nm  = (nm == "") ? "rand_rd" : nm;
         exp_q.push_back(e);
`ifdef AVR_DATA_MEM_TIMER_EN
         if (a == 16'h0044) ttmp_m = cyc[15:8];
`endif
      end
      if (w) model_write(a, d);
      @(negedge clk);
      wen = 1'b0; ren = 1'b0;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) op(1'b0, 1'b0, 16'h0000, 8'h00, -1, "");
   endtask

   task automatic do_reset();
      #2 reset = 1'b0;
      #1;
      chk("async_rst_uart_tx", {7'b0, uart_tx}, 8'h01);
      chk("async_rst_gpio_out", gpio_out, 8'h00);
      chk("async_rst_rdata", rdata, 8'h00);
      portb_m  = '0;
      ovr_m    = 1'b0;
      tx_start = -100000;
      ttmp_m   = '0;
      gpio_at.delete();
      repeat (2) @(negedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboard for each read, checks hold, GPIO and serial line every cycle.
   initial begin
      bit         pend;
      logic [7:0] last_v;
      bit         last_ok;
      exp_t       e;
      last_v  = '0;
      last_ok = 1'b1;
      forever begin
         @(posedge clk);
         pend = ren && reset;
         if (reset) gpio_at[cyc] = gpio_in;
         @(negedge clk);
         if (!reset) begin
            last_v  = '0;
            last_ok = 1'b1;
            continue;
         end
         if (pend) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL scoreboard_underflow: read with no expectation (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.chk) chk(e.nm, rdata, e.v);
               last_v  = e.v;
               last_ok = e.chk;
            end
         end else if (last_ok) begin
            chk("rdata_hold", rdata, last_v);
         end
         chk("gpio_out", gpio_out, portb_m);
         chk("uart_tx", {7'b0, uart_tx}, {7'b0, tx_model(cyc)});
      end
   end

   initial begin
      logic [9:0]  seq;
      logic [15:0] a;
      int          sel;

      repeat (2) @(negedge clk);
      chk("rst_rdata", rdata, 8'h00);
      chk("rst_gpio_out", gpio_out, 8'h00);
      chk("rst_uart_tx", {7'b0, uart_tx}, 8'h01);
      #1 reset = 1'b1;
      @(negedge clk);

      // SRAM, aliasing and stack at top of RAM
      op(1, 0, 16'h0100, 8'hA5, -1, "");
      op(0, 1, 16'h0100, 8'h00, 8'hA5, "sram_rd");
      op(0, 1, 16'h0500, 8'h00, 8'hA5, "sram_alias");
      op(1, 0, 16'hFFFF, 8'h12, -1, "");
      op(1, 0, 16'hFFFE, 8'h34, -1, "");
      op(0, 1, 16'h03FF, 8'h00, 8'h12, "stack_hi");
      op(0, 1, 16'h03FE, 8'h00, 8'h34, "stack_lo");
      op(1, 1, 16'h0100, 8'h77, 8'hA5, "rw_same_old");
      op(0, 1, 16'h0100, 8'h00, 8'h77, "rw_same_new");

      // GPIO
      op(1, 0, 16'h0025, 8'h5A, -1, "");
      chk("gpio_out_5a", gpio_out, 8'h5A);
      op(0, 1, 16'h0025, 8'h00, 8'h5A, "portb_rd");
      #1 gpio_in = 8'hC3;
      @(negedge clk);
      op(0, 1, 16'h0023, 8'h00, 8'h00, "pinb_early");
      op(0, 1, 16'h0023, 8'h00, 8'hC3, "pinb_sync");

      // Unmapped and undecoded locations
      op(1, 0, 16'h0010, 8'hFF, -1, "");
      op(0, 1, 16'h0010, 8'h00, 8'h00, "unmapped");
      op(0, 1, 16'h0030, 8'h00, 8'h00, "io_undecoded");
      op(0, 1, 16'h0046, 8'h00, 8'h00, "udr_read");
`ifndef AVR_DATA_MEM_TIMER_EN
      op(0, 1, 16'h0044, 8'h00, 8'h00, "tcntl_absent");
      op(0, 1, 16'h0045, 8'h00, 8'h00, "tcnth_absent");
`endif

      // UART frame of 0x55 with overrun set and cleared mid-frame
      seq = 10'h2AA;
      op(1, 0, 16'h0046, 8'h55, -1, "");
      for (int i = 0; i < FRAME; i++) begin
         chk("frame_bit", {7'b0, uart_tx}, {7'b0, seq[i / CD]});
         case (i)
            5:       op(0, 1, 16'h0047, 8'h00, 8'h01, "ustat_busy");
            8:       op(1, 0, 16'h0046, 8'hAA, -1, "");
            9:       op(0, 1, 16'h0047, 8'h00, 8'h03, "ustat_overrun");
            10:      op(1, 0, 16'h0047, 8'h02, -1, "");
            11:      op(0, 1, 16'h0047, 8'h00, 8'h01, "ustat_cleared");
            default: idle(1);
         endcase
      end
      chk("frame_end_idle", {7'b0, uart_tx}, 8'h01);
      op(0, 1, 16'h0047, 8'h00, 8'h00, "ustat_done");

      // Reset in the middle of a frame, with overrun pending and line low
      op(1, 0, 16'h0025, 8'h3C, -1, "");
      op(1, 0, 16'h0046, 8'hF0, -1, "");
      op(1, 0, 16'h0046, 8'h11, -1, "");
      op(0, 1, 16'h0025, 8'h00, 8'h3C, "portb_pre_rst");
      idle(4 * CD - 2);
      chk("tx_low_pre_rst", {7'b0, uart_tx}, 8'h00);
      do_reset();
      op(0, 1, 16'h0047, 8'h00, 8'h00, "ustat_after_rst");
      op(0, 1, 16'h0025, 8'h00, 8'h00, "portb_after_rst");

`ifdef AVR_DATA_MEM_TIMER_EN
      for (int g = 0; g < 1000 && cyc != 32'h1FF; g++) idle(1);
      n_cmp++;
      if (cyc != 32'h1FF) begin
         n_bad++;
         $display("FAIL timer_wait: cycle %0d expected %0d", cyc, 32'h1FF);
      end
      op(0, 1, 16'h0044, 8'h00, 8'hFF, "tcntl");
      idle(3);
      op(0, 1, 16'h0045, 8'h00, 8'h01, "tcnth");
`endif

      // Random traffic
      for (int n = 0; n < 1500; n++) begin
         sel = int'($urandom_range(0, 9));
         case (sel)
            0, 1:    a = 16'(16'h0060 + $urandom_range(0, 63));
            2, 3:    a = 16'(32'h0200 + $urandom_range(0, 31) + RAM_SZ * $urandom_range(0, 60));
            4:       a = $urandom_range(0, 1) ? 16'h0023 : 16'h0025;
            5:       a = $urandom_range(0, 1) ? 16'h0044 : 16'h0045;
            6:       a = $urandom_range(0, 1) ? 16'h0046 : 16'h0047;
            7:       a = 16'($urandom_range(0, 31));
            default: a = 16'($urandom_range(32, 95));
         endcase
         if ($urandom_range(0, 15) == 0) gpio_in = 8'($urandom);
         op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, 8'($urandom), -1, "");
      end

      idle(3);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
